// File: rtl/latency_probe_sched.sv
// latency_probe_sched
//
// Shares the compute-engine AXI stream between user packets and internally
// generated latency probes. Probes are injected only at packet boundaries,
// at a programmable period, and carry a marker word plus a timestamp taken
// from the shared timekeeper. A passive tap on the return stream recognises
// probe packets and measures how long they took to come back.
//
// Ports
//   ce_clk, ce_rst                     clock, synchronous active-high reset
//   set_stb, set_addr, set_data        settings bus (enable, period, clear)
//   timer                              free-running timekeeper, [31:0] used
//   in_tdata/in_tlast/in_tvalid/in_tready      user packet stream
//   out_tdata/out_tlast/out_tvalid/out_tready  arbitrated output stream
//   mon_tdata/mon_tlast/mon_tvalid/mon_tready  passive tap of return stream
//   lat_tdata, lat_tvalid              last latency, one-cycle strobe
//   max_lat                            largest latency since clear
//   probe_cnt, miss_cnt                probes issued, period expiries missed
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | between packets; picks a pending probe first, else user data
// DATA  | user packet passes straight through until its tlast beat
// PROBE | probe words driven from registered state until the last word
module latency_probe_sched #(
    parameter logic [31:0] MARKER    = 32'hABCDBEEF,
    parameter int          PROBE_LEN = 4,
    parameter int          SR_BASE   = 128
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] timer,
    input  logic [31:0] in_tdata,
    input  logic        in_tlast,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [31:0] out_tdata,
    output logic        out_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    input  logic [31:0] mon_tdata,
    input  logic        mon_tlast,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    output logic [31:0] lat_tdata,
    output logic        lat_tvalid,
    output logic [31:0] max_lat,
    output logic [15:0] probe_cnt,
    output logic [15:0] miss_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PROBE} state_t;

    localparam logic [7:0] ADDR_EN  = 8'(SR_BASE);
    localparam logic [7:0] ADDR_PER = 8'(SR_BASE + 1);
    localparam logic [7:0] ADDR_CLR = 8'(SR_BASE + 2);
    localparam logic [7:0] W_LAST   = 8'(PROBE_LEN - 1);

    state_t      state_q, state_d;
    logic        enable_q, enable_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic [31:0] ts_q, ts_d;
    logic [7:0]  w_q, w_d;
    logic [15:0] probe_cnt_q, probe_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        sop_q, sop_d;
    logic        armed_q, armed_d;
    logic [31:0] lat_q, lat_d;
    logic        lat_vld_q, lat_vld_d;
    logic [31:0] max_lat_q, max_lat_d;

    logic        wr_en, wr_per, wr_clr;
    logic        expire;
    logic        mon_beat;
    logic [31:0] lat_calc;
    logic        unused_timer_hi;

    assign unused_timer_hi = ^timer[63:32];

    assign wr_en  = set_stb && (set_addr == ADDR_EN);
    assign wr_per = set_stb && (set_addr == ADDR_PER);
    assign wr_clr = set_stb && (set_addr == ADDR_CLR);

    // A settings write to enable/period restarts the period, so it also
    // suppresses an expiry that would otherwise land on the same edge.
    assign expire = enable_q && (period_q != 32'd0) && (cnt_q == period_q - 32'd1)
                    && !(wr_en || wr_per);

    assign mon_beat = mon_tvalid && mon_tready;
    assign lat_calc = timer[31:0] - mon_tdata;

    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        ts_d        = ts_q;
        w_d         = w_q;
        probe_cnt_d = probe_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        sop_d       = sop_q;
        armed_d     = armed_q;
        lat_d       = lat_q;
        lat_vld_d   = 1'b0;
        max_lat_d   = max_lat_q;
        out_tvalid  = 1'b0;
        out_tlast   = 1'b0;
        out_tdata   = 32'd0;
        in_tready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_PROBE;
                    ts_d      = timer[31:0];
                    w_d       = 8'd0;
                    pending_d = 1'b0;
                end else if (in_tvalid) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                out_tdata  = in_tdata;
                out_tlast  = in_tlast;
                out_tvalid = in_tvalid;
                in_tready  = out_tready;
                if (in_tvalid && out_tready && in_tlast) begin
                    state_d = S_IDLE;
                end
            end
            S_PROBE: begin
                out_tvalid = 1'b1;
                out_tlast  = (w_q == W_LAST);
                case (w_q)
                    8'd0:    out_tdata = MARKER;
                    8'd1:    out_tdata = ts_q;
                    default: out_tdata = {16'h0, probe_cnt_q};
                endcase
                if (out_tready) begin
                    if (w_q == W_LAST) begin
                        state_d     = S_IDLE;
                        probe_cnt_d = probe_cnt_q + 16'd1;
                    end else begin
                        w_d = w_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en) begin
            enable_d = set_data[0];
        end
        if (wr_per) begin
            period_d = set_data;
        end

        if (wr_en || wr_per) begin
            cnt_d = 32'd0;
        end else if (enable_q && (period_q != 32'd0)) begin
            cnt_d = expire ? 32'd0 : cnt_q + 32'd1;
        end

        // Uses the pre-edge pending flag: an expiry that coincides with the
        // IDLE->PROBE hand-off is counted as a miss, not as a new probe.
        if (expire) begin
            if (pending_q) begin
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_d = miss_cnt_q + 16'd1;
                end
            end else begin
                pending_d = 1'b1;
            end
        end

        if (mon_beat) begin
            sop_d = mon_tlast;
            if (armed_q) begin
                armed_d   = 1'b0;
                lat_d     = lat_calc;
                lat_vld_d = 1'b1;
                if (lat_calc > max_lat_q) begin
                    max_lat_d = lat_calc;
                end
            end else if (sop_q && (mon_tdata == MARKER) && !mon_tlast) begin
                armed_d = 1'b1;
            end
        end

        // Clear is applied last so it beats any same-edge increment.
        if (wr_clr) begin
            probe_cnt_d = 16'd0;
            miss_cnt_d  = 16'd0;
            max_lat_d   = 32'd0;
        end
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            period_q    <= 32'd0;
            cnt_q       <= 32'd0;
            pending_q   <= 1'b0;
            ts_q        <= 32'd0;
            w_q         <= 8'd0;
            probe_cnt_q <= 16'd0;
            miss_cnt_q  <= 16'd0;
            sop_q       <= 1'b1;
            armed_q     <= 1'b0;
            lat_q       <= 32'd0;
            lat_vld_q   <= 1'b0;
            max_lat_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            ts_q        <= ts_d;
            w_q         <= w_d;
            probe_cnt_q <= probe_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            sop_q       <= sop_d;
            armed_q     <= armed_d;
            lat_q       <= lat_d;
            lat_vld_q   <= lat_vld_d;
            max_lat_q   <= max_lat_d;
        end
    end

    assign lat_tdata  = lat_q;
    assign lat_tvalid = lat_vld_q;
    assign max_lat    = max_lat_q;
    assign probe_cnt  = probe_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
